// File: rtl/dram_io_pkg.sv
// Shared definitions for the 16-chip DRAM board emulator: geometry, read-address
// field layout and the emulator control state.
package dram_io_pkg;
  localparam int unsigned NCHIP  = 16;
  localparam int unsigned ROWS   = 64;
  localparam int unsigned ROW_AW = $clog2(ROWS);
  localparam int unsigned WORD_W = 64;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned CNT_W  = 2;

  localparam int unsigned RA_W       = 8;
  localparam int unsigned RA_ROW_MSB = 7;
  localparam int unsigned RA_ROW_LSB = 2;
  localparam int unsigned RA_DMX_MSB = 1;
  localparam int unsigned RA_DMX_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_COMMIT,
    ST_RD_WAIT,
    ST_RD_DONE
  } emu_state_e;
endpackage

// File: rtl/dram_emu_piso8.sv
// 8-bit parallel-in/serial-out lane: level load while sr_ld=0, MSB-first shift
// with zero fill on each rise of the (already synchronised) effective clock.
module dram_emu_piso8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] load_data,
  input  logic       sr_ld,
  input  logic       eff_clk,
  output logic       sout
);
  logic [7:0] piso_q, piso_d;
  logic       eff_prev_q;

  always_comb begin
    piso_d = piso_q;
    if (!sr_ld)
      piso_d = load_data;
    else if (eff_clk && !eff_prev_q)
      piso_d = {piso_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_q     <= '0;
      eff_prev_q <= 1'b0;
    end else begin
      piso_q     <= piso_d;
      eff_prev_q <= eff_clk;
    end
  end

  assign sout = piso_q[7];
endmodule

// File: rtl/dram16_chip_emulator.sv
// Chip-side emulation of the 16-chip DRAM board: serial address/data/read-address
// capture, per-chip row storage, latency-timed byte readout through PISO lanes.
module dram16_chip_emulator
  import dram_io_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_out,
  input  logic             ADD_IN,
  input  logic             ADD_VALID_IN,
  input  logic [1:0]       PC_D_IN,
  input  logic [NCHIP-1:0] D_IN,
  input  logic             DATA_VALID_IN,
  input  logic             WRI_EN,
  input  logic [1:0]       PC_R_AD,
  input  logic [NCHIP-1:0] R_AD,
  input  logic             DE_ADD3,
  input  logic             RD_EN,
  input  logic [2:0]       PC_data,
  output logic [NCHIP-1:0] DRAM16_data,
  output logic             emu_busy,
  output logic             emu_err
);
  logic             clk_out_q, add_in_q, add_valid_q, dv_q, wri_q, de_add3_q, rd_en_q;
  logic [1:0]       pc_d_in_q, pc_r_ad_q;
  logic [NCHIP-1:0] d_in_q, r_ad_q;
  logic [2:0]       pc_data_q;
  logic             clk_out_p_q, pcd_p_q, pcr_p_q, wri_p_q, rd_p_q;

  logic [ROW_AW-1:0]                  addr_sr_q, addr_sr_d;
  logic [NCHIP-1:0][WORD_W-1:0]       data_sr_q, data_sr_d;
  logic [NCHIP-1:0][RA_W-1:0]         ra_sr_q, ra_sr_d;

  emu_state_e                         state_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               err_q;
  logic [NCHIP-1:0][ROW_AW-1:0]       rd_row_q;
  logic [NCHIP-1:0][2:0]              rd_b_q;
  logic [NCHIP-1:0][7:0]              rd_buf_q;
  logic [7:0]                         rd_byte [NCHIP];

  logic addr_rise, pcd_rise, pcr_rise, wri_rise, rd_rise, wr_commit, eff_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out_q <= 1'b0; add_in_q <= 1'b0; add_valid_q <= 1'b0; dv_q <= 1'b0;
      wri_q <= 1'b0; de_add3_q <= 1'b0; rd_en_q <= 1'b0;
      pc_d_in_q <= '0; pc_r_ad_q <= '0; d_in_q <= '0; r_ad_q <= '0; pc_data_q <= '0;
      clk_out_p_q <= 1'b0; pcd_p_q <= 1'b0; pcr_p_q <= 1'b0; wri_p_q <= 1'b0; rd_p_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out; add_in_q <= ADD_IN; add_valid_q <= ADD_VALID_IN; dv_q <= DATA_VALID_IN;
      wri_q <= WRI_EN; de_add3_q <= DE_ADD3; rd_en_q <= RD_EN;
      pc_d_in_q <= PC_D_IN; pc_r_ad_q <= PC_R_AD; d_in_q <= D_IN; r_ad_q <= R_AD; pc_data_q <= PC_data;
      clk_out_p_q <= clk_out_q; pcd_p_q <= pc_d_in_q[0]; pcr_p_q <= pc_r_ad_q[0];
      wri_p_q <= wri_q; rd_p_q <= rd_en_q;
    end
  end

  assign addr_rise = clk_out_q    & ~clk_out_p_q;
  assign pcd_rise  = pc_d_in_q[0] & ~pcd_p_q;
  assign pcr_rise  = pc_r_ad_q[0] & ~pcr_p_q;
  assign wri_rise  = wri_q        & ~wri_p_q;
  assign rd_rise   = rd_en_q      & ~rd_p_q;
  assign wr_commit = (state_q == ST_WR_COMMIT);
  assign eff_clk   = pc_data_q[0] ^ pc_data_q[2];

  always_comb begin
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    ra_sr_d   = ra_sr_q;
    if (addr_rise && add_valid_q)
      addr_sr_d = {addr_sr_q[ROW_AW-2:0], add_in_q};
    if (!pc_d_in_q[1])
      data_sr_d = '0;
    else if (pcd_rise)
      for (int unsigned i = 0; i < NCHIP; i++)
        data_sr_d[i] = {data_sr_q[i][WORD_W-2:0], d_in_q[i]};
    if (!pc_r_ad_q[1])
      ra_sr_d = '0;
    else if (pcr_rise)
      for (int unsigned i = 0; i < NCHIP; i++)
        ra_sr_d[i] = {ra_sr_q[i][RA_W-2:0], r_ad_q[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sr_q <= '0;
      data_sr_q <= '0;
      ra_sr_q   <= '0;
    end else begin
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      ra_sr_q   <= ra_sr_d;
    end
  end

  // A simultaneous WRI_EN/RD_EN rise is resolved in favour of the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_row_q <= '0;
      rd_b_q   <= '0;
      rd_buf_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wri_rise) begin
            if (dv_q) state_q <= ST_WR_COMMIT;
            if (!dv_q || rd_rise) err_q <= 1'b1;
          end else if (rd_rise) begin
            state_q <= ST_RD_WAIT;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < NCHIP; i++) begin
              rd_row_q[i] <= ra_sr_q[i][RA_ROW_MSB:RA_ROW_LSB];
              rd_b_q[i]   <= {de_add3_q, ra_sr_q[i][RA_DMX_MSB:RA_DMX_LSB]};
            end
          end
        end
        ST_WR_COMMIT: begin
          if (wri_rise || rd_rise) err_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (wri_rise || rd_rise) err_q <= 1'b1;
          if (cnt_q == CNT_W'(RD_LAT - 2)) begin
            for (int unsigned i = 0; i < NCHIP; i++)
              rd_buf_q[i] <= rd_byte[i];
            state_q <= ST_RD_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RD_DONE: begin
          if (wri_rise || rd_rise) err_q <= 1'b1;
          if (!rd_en_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign emu_busy = (state_q != ST_IDLE);
  assign emu_err  = err_q;

  for (genvar g = 0; g < NCHIP; g++) begin : g_lane
    logic [WORD_W-1:0] mem [ROWS];
    logic [WORD_W-1:0] rd_word_q;

    // Storage is deliberately unreset; the read port is registered for block RAM mapping.
    always_ff @(posedge clk) begin
      if (wr_commit) mem[addr_sr_q] <= data_sr_q[g];
      rd_word_q <= mem[rd_row_q[g]];
    end

    assign rd_byte[g] = rd_word_q[{rd_b_q[g], 3'b000} +: 8];

    dram_emu_piso8 u_piso (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_data (rd_buf_q[g]),
      .sr_ld     (pc_data_q[1]),
      .eff_clk   (eff_clk),
      .sout      (DRAM16_data[g])
    );
  end
endmodule
